// File: rtl/vga_scan_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_gen
// Description : VGA raster scan generator with pixel/line counters, sync and
//               blanking decode, frame-start pulse and wrapping frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [10:0] hor_reg,
  output logic [9:0]  ver_reg,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam logic [10:0] c_h_last     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] c_h_active   = 11'(H_ACTIVE);
  localparam logic [10:0] c_hs_start   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_hs_end     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  c_v_last     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  c_v_active   = 10'(V_ACTIVE);
  localparam logic [9:0]  c_vs_start   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  c_vs_end     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] r_hor;
  logic [9:0]  r_ver;
  logic        r_hs;
  logic        r_vs;
  logic        r_von;
  logic        r_fs;
  logic [7:0]  r_fcnt;

  logic        w_h_end;
  logic        w_v_end;
  logic [10:0] w_h_nxt;
  logic [9:0]  w_v_nxt;
  logic        w_hs_nxt;
  logic        w_vs_nxt;
  logic        w_von_nxt;
  logic        w_fs_nxt;

  // Decode from the next counter values so the registered flags land on the
  // same edge as the position they describe.
  always_comb begin
    w_h_end   = (r_hor == c_h_last);
    w_v_end   = (r_ver == c_v_last);
    w_h_nxt   = w_h_end ? 11'd0 : r_hor + 11'd1;
    w_v_nxt   = r_ver;
    if (w_h_end) begin
      w_v_nxt = w_v_end ? 10'd0 : r_ver + 10'd1;
    end
    w_hs_nxt  = (w_h_nxt >= c_hs_start) && (w_h_nxt < c_hs_end);
    w_vs_nxt  = (w_v_nxt >= c_vs_start) && (w_v_nxt < c_vs_end);
    w_von_nxt = (w_h_nxt < c_h_active) && (w_v_nxt < c_v_active);
    w_fs_nxt  = (w_h_nxt == 11'd0) && (w_v_nxt == 10'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hor  <= 11'd0;
      r_ver  <= 10'd0;
      r_hs   <= ~SYNC_POL;
      r_vs   <= ~SYNC_POL;
      r_von  <= 1'b0;
      r_fs   <= 1'b0;
      r_fcnt <= 8'd0;
    end else begin
      r_fs <= 1'b0;
      if (en) begin
        r_hor <= w_h_nxt;
        r_ver <= w_v_nxt;
        r_hs  <= w_hs_nxt ? SYNC_POL : ~SYNC_POL;
        r_vs  <= w_vs_nxt ? SYNC_POL : ~SYNC_POL;
        r_von <= w_von_nxt;
        r_fs  <= w_fs_nxt;
        if (w_h_end && w_v_end) begin
          r_fcnt <= r_fcnt + 8'd1;
        end
      end
    end
  end

  assign hor_reg     = r_hor;
  assign ver_reg     = r_ver;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign video_on    = r_von;
  assign frame_start = r_fs;
  assign frame_cnt   = r_fcnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scan_gen
// Description : Directed self-checking bench for vga_scan_gen on a reduced
//               15x8 raster (H 8/2/3/2, V 4/1/2/1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_gen;

  localparam int c_ht = 15;
  localparam int c_vt = 8;

  logic        clk;
  logic        rst;
  logic        en;
  logic [10:0] hor_reg;
  logic [9:0]  ver_reg;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  int checks;
  int errors;

  vga_scan_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .hor_reg(hor_reg), .ver_reg(ver_reg),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {hor, ver, hsync, vsync, video_on, frame_start, frame_cnt}
  // after n enabled edges from reset release, derived from the raster size.
  function automatic logic [32:0] exp_vec(input int n);
    int p, h, v;
    p = n % (c_ht * c_vt);
    h = p % c_ht;
    v = p / c_ht;
    exp_vec = {11'(h), 10'(v), (h >= 10 && h <= 12), (v >= 5 && v <= 6),
               (h < 8 && v < 4), (h == 0 && v == 0), 8'((n / (c_ht * c_vt)) % 256)};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (hor_reg !== 11'd0) begin errors++; $display("FAIL reset_hor got %0d exp 0", hor_reg); end
    checks++; if (ver_reg !== 10'd0) begin errors++; $display("FAIL reset_ver got %0d exp 0", ver_reg); end
    checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL reset_hsync got %b exp 0", hsync); end
    checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync got %b exp 0", vsync); end
    checks++; if (video_on !== 1'b0) begin errors++; $display("FAIL reset_video_on got %b exp 0", video_on); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b exp 0", frame_start); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
  endtask

  task automatic test_free_run();
    logic [32:0] act;
    logic [32:0] exp;
    int pulses, last;
    pulses = 0;
    last   = 0;
    rst = 1'b1;
    en  = 1'b1;
    for (int n = 1; n <= 2 * c_ht * c_vt; n++) begin
      @(negedge clk);
      act = {hor_reg, ver_reg, hsync, vsync, video_on, frame_start, frame_cnt};
      exp = exp_vec(n);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL free_run n=%0d got h=%0d v=%0d hs=%b vs=%b von=%b fs=%b fc=%0d exp h=%0d v=%0d hs=%b vs=%b von=%b fs=%b fc=%0d",
                 n, act[32:22], act[21:12], act[11], act[10], act[9], act[8], act[7:0],
                 exp[32:22], exp[21:12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
      end
      if (frame_start === 1'b1) begin
        if (pulses > 0) begin
          checks++;
          if (n - last !== c_ht * c_vt) begin
            errors++; $display("FAIL frame_start_spacing got %0d exp %0d", n - last, c_ht * c_vt);
          end
        end
        pulses++;
        last = n;
      end
    end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL frame_start_count got %0d exp 2", pulses); end
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL frame_cnt_two got %0d exp 2", frame_cnt); end
  endtask

  task automatic test_en_hold();
    // Sitting at (0,0) with frame_start high: dropping en must kill the pulse.
    en = 1'b0;
    @(negedge clk);
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL hold00_fs got %b exp 0", frame_start); end
    checks++; if ({hor_reg, ver_reg} !== 21'd0) begin errors++; $display("FAIL hold00_pos got (%0d,%0d) exp (0,0)", hor_reg, ver_reg); end
    checks++; if (video_on !== 1'b1) begin errors++; $display("FAIL hold00_von got %b exp 1", video_on); end
    repeat (3) @(negedge clk);
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL hold00_repulse got %b exp 0", frame_start); end
    en = 1'b1;
    repeat (9) @(negedge clk);
    checks++; if (hor_reg !== 11'd9 || hsync !== 1'b0) begin errors++; $display("FAIL pre_sync got h=%0d hs=%b exp h=9 hs=0", hor_reg, hsync); end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (hor_reg !== 11'd9 || ver_reg !== 10'd0 || hsync !== 1'b0 || vsync !== 1'b0 || frame_start !== 1'b0 || frame_cnt !== 8'd2) begin
        errors++;
        $display("FAIL frozen i=%0d got h=%0d v=%0d hs=%b vs=%b fs=%b fc=%0d exp h=9 v=0 hs=0 vs=0 fs=0 fc=2",
                 i, hor_reg, ver_reg, hsync, vsync, frame_start, frame_cnt);
      end
    end
    en = 1'b1;
    @(negedge clk);
    checks++; if (hor_reg !== 11'd10 || hsync !== 1'b1) begin errors++; $display("FAIL resume_sync got h=%0d hs=%b exp h=10 hs=1", hor_reg, hsync); end
  endtask

  task automatic test_wrap();
    // From (10,0) frame 2: 110 edges to frame 3, 252 frames to frame 255, 119 to (14,7).
    repeat (110 + 252 * c_ht * c_vt + 119) @(negedge clk);
    checks++;
    if (hor_reg !== 11'd14 || ver_reg !== 10'd7 || frame_cnt !== 8'd255 || video_on !== 1'b0 || vsync !== 1'b0) begin
      errors++;
      $display("FAIL pre_wrap got h=%0d v=%0d fc=%0d von=%b vs=%b exp h=14 v=7 fc=255 von=0 vs=0",
               hor_reg, ver_reg, frame_cnt, video_on, vsync);
    end
    @(negedge clk);
    checks++;
    if (hor_reg !== 11'd0 || ver_reg !== 10'd0 || frame_cnt !== 8'd0 || frame_start !== 1'b1 || video_on !== 1'b1 || vsync !== 1'b0) begin
      errors++;
      $display("FAIL wrap got h=%0d v=%0d fc=%0d fs=%b von=%b vs=%b exp h=0 v=0 fc=0 fs=1 von=1 vs=0",
               hor_reg, ver_reg, frame_cnt, frame_start, video_on, vsync);
    end
  endtask

  task automatic test_async_reset();
    repeat (34) @(negedge clk);
    checks++; if (hor_reg !== 11'd4 || ver_reg !== 10'd2 || video_on !== 1'b1) begin errors++; $display("FAIL mid_frame got h=%0d v=%0d von=%b exp h=4 v=2 von=1", hor_reg, ver_reg, video_on); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (hor_reg !== 11'd0 || ver_reg !== 10'd0 || hsync !== 1'b0 || vsync !== 1'b0 || video_on !== 1'b0 || frame_start !== 1'b0 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_rst got h=%0d v=%0d hs=%b vs=%b von=%b fs=%b fc=%0d exp all 0",
               hor_reg, ver_reg, hsync, vsync, video_on, frame_start, frame_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (hor_reg !== 11'd1 || ver_reg !== 10'd0 || video_on !== 1'b1 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL post_rst got h=%0d v=%0d von=%b fs=%b exp h=1 v=0 von=1 fs=0", hor_reg, ver_reg, video_on, frame_start);
    end
    @(negedge clk);
    checks++; if (hor_reg !== 11'd2 || frame_start !== 1'b0) begin errors++; $display("FAIL post_rst2 got h=%0d fs=%b exp h=2 fs=0", hor_reg, frame_start); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    en     = 1'b0;
    test_reset();
    test_free_run();
    test_en_hold();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
